// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the fetch stage: address map and CP0 exception codes
// (the exception codes are also used by CP0 and the later pipeline stages).
package if_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: the control inputs from D/CP0, the instruction-memory port
// and the F-stage bundle. The fetch unit is the master.
interface if_fetch_unit_if;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        is_jb_D;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic [31:0] IR_F;
  logic [31:0] PC_F;
  logic [31:0] PC4_F;
  logic [31:0] PC8_F;
  logic        BD_F;
  logic        exc_F;
  logic [4:0]  exc_code_F;
  logic        clr_FD;

  modport master (
    input  stall, redir_valid, redir_pc, is_jb_D, exc_req, eret_req, epc, im_data,
    output im_addr, IR_F, PC_F, PC4_F, PC8_F, BD_F, exc_F, exc_code_F, clr_FD
  );

  modport slave (
    output stall, redir_valid, redir_pc, is_jb_D, exc_req, eret_req, epc, im_data,
    input  im_addr, IR_F, PC_F, PC4_F, PC8_F, BD_F, exc_F, exc_code_F, clr_FD
  );
endinterface

// File: rtl/if_fetch_unit_npc_sel.sv
// Next-PC priority mux: exception entry, ERET return, stall hold, D-stage
// redirect, then sequential PC+4.
module if_npc_sel #(
  parameter logic [31:0] EXC_PC = if_fetch_unit_pkg::EXC_PC
) (
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_pc_i,
  input  logic        exc_req_i,
  input  logic        eret_req_i,
  input  logic [31:0] epc_i,
  output logic [31:0] pc_o
);

  always_comb begin
    pc_o = pc_i + 32'd4;
    if (exc_req_i) begin
      pc_o = EXC_PC;
    end else if (eret_req_i) begin
      pc_o = epc_i;
    end else if (stall_i) begin
      // D is frozen, so a redirect seen now is presented again once stall drops
      pc_o = pc_i;
    end else if (redir_valid_i) begin
      pc_o = redir_pc_i;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, IM addressing, fetch-address
// fault detection and the F-stage bundle for the F/D register.
module if_fetch_unit
  import if_fetch_unit_pkg::EXC_ADEL;
  import if_fetch_unit_pkg::EXC_INT;
#(
  parameter logic [31:0] RESET_PC = if_fetch_unit_pkg::RESET_PC,
  parameter logic [31:0] EXC_PC   = if_fetch_unit_pkg::EXC_PC,
  parameter logic [31:0] TEXT_LO  = if_fetch_unit_pkg::TEXT_LO,
  parameter logic [31:0] TEXT_HI  = if_fetch_unit_pkg::TEXT_HI
) (
  input logic            clk,
  input logic            reset,
  if_fetch_unit_if.master fif
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        fault;

  if_npc_sel #(
    .EXC_PC (EXC_PC)
  ) u_npc_sel (
    .pc_i          (pc_q),
    .stall_i       (fif.stall),
    .redir_valid_i (fif.redir_valid),
    .redir_pc_i    (fif.redir_pc),
    .exc_req_i     (fif.exc_req),
    .eret_req_i    (fif.eret_req),
    .epc_i         (fif.epc),
    .pc_o          (pc_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // A wrapped PC+4 lands below TEXT_LO, so the range check also covers wrap
  assign fault = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);

  assign fif.im_addr    = pc_q;
  assign fif.PC_F       = pc_q;
  assign fif.PC4_F      = pc_q + 32'd4;
  assign fif.PC8_F      = pc_q + 32'd8;
  assign fif.IR_F       = fault ? 32'h0000_0000 : fif.im_data;
  assign fif.exc_F      = fault;
  assign fif.exc_code_F = fault ? EXC_ADEL : EXC_INT;
  assign fif.BD_F       = fif.is_jb_D;
  assign fif.clr_FD     = fif.exc_req | fif.eret_req;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: expected F-stage bundles are queued as each
// step is driven and popped against the DUT outputs shortly afterwards.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .fif   (bus)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0001;
    return {16'h2409, a[15:0]};
  endfunction

  assign bus.im_data = imem(bus.im_addr);

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_f(input logic [31:0] pc, input logic bd, input logic clr);
    logic flt;
    logic [31:0] p4;
    logic [31:0] p8;
    flt = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
    p4  = pc + 32'd4;
    p8  = pc + 32'd8;
    push("im_addr", pc);
    push("PC_F", pc);
    push("PC4_F", p4);
    push("PC8_F", p8);
    push("IR_F", flt ? 32'h0 : imem(pc));
    push("exc_F", {31'b0, flt});
    push("exc_code_F", flt ? 32'd4 : 32'd0);
    push("BD_F", {31'b0, bd});
    push("clr_FD", {31'b0, clr});
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: nothing expected, observed %h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic observe();
    #1;
    cmp(bus.im_addr);
    cmp(bus.PC_F);
    cmp(bus.PC4_F);
    cmp(bus.PC8_F);
    cmp(bus.IR_F);
    cmp({31'b0, bus.exc_F});
    cmp({27'b0, bus.exc_code_F});
    cmp({31'b0, bus.BD_F});
    cmp({31'b0, bus.clr_FD});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset           = 1'b1;
    bus.stall       = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0;
    bus.is_jb_D     = 1'b0;
    bus.exc_req     = 1'b0;
    bus.eret_req    = 1'b0;
    bus.epc         = 32'h0;
    #12;
    reset = 1'b0;
    expect_f(32'h3000, 1'b0, 1'b0); observe();
    tick(); expect_f(32'h3004, 1'b0, 1'b0); observe();
    tick(); expect_f(32'h3008, 1'b0, 1'b0); observe();

    // mid-cycle reset pulse: PC must return before the next edge
    reset = 1'b1;
    expect_f(32'h3000, 1'b0, 1'b0); observe();
    reset = 1'b0;
    tick(); expect_f(32'h3004, 1'b0, 1'b0); observe();
    tick(); expect_f(32'h3008, 1'b0, 1'b0); observe();

    bus.stall = 1'b1;
    tick(); expect_f(32'h3008, 1'b0, 1'b0); observe();
    tick(); expect_f(32'h3008, 1'b0, 1'b0); observe();
    bus.stall = 1'b0;
    tick(); expect_f(32'h300C, 1'b0, 1'b0); observe();
    tick(); expect_f(32'h3010, 1'b0, 1'b0); observe();

    // branch in D: delay-slot instruction stays in F this cycle
    bus.redir_valid = 1'b1; bus.redir_pc = 32'h3100; bus.is_jb_D = 1'b1;
    expect_f(32'h3010, 1'b1, 1'b0); observe();
    tick();
    bus.redir_valid = 1'b0; bus.is_jb_D = 1'b0;
    expect_f(32'h3100, 1'b0, 1'b0); observe();

    bus.redir_valid = 1'b1; bus.redir_pc = 32'h3010;
    tick();
    bus.redir_valid = 1'b0;
    expect_f(32'h3010, 1'b0, 1'b0); observe();

    // redirect under stall is ignored until stall drops
    bus.stall = 1'b1; bus.redir_valid = 1'b1; bus.redir_pc = 32'h3100; bus.is_jb_D = 1'b1;
    expect_f(32'h3010, 1'b1, 1'b0); observe();
    tick(); expect_f(32'h3010, 1'b1, 1'b0); observe();
    bus.stall = 1'b0;
    tick();
    bus.redir_valid = 1'b0; bus.is_jb_D = 1'b0;
    expect_f(32'h3100, 1'b0, 1'b0); observe();

    bus.redir_valid = 1'b1; bus.redir_pc = 32'h3020;
    tick();
    bus.redir_valid = 1'b0;
    expect_f(32'h3020, 1'b0, 1'b0); observe();

    // exception beats ERET and stall
    bus.stall = 1'b1; bus.exc_req = 1'b1; bus.eret_req = 1'b1; bus.epc = 32'h3024;
    expect_f(32'h3020, 1'b0, 1'b1); observe();
    tick();
    bus.exc_req = 1'b0; bus.stall = 1'b0;
    expect_f(32'h4180, 1'b0, 1'b1); observe();
    tick();
    bus.eret_req = 1'b0;
    expect_f(32'h3024, 1'b0, 1'b0); observe();

    // fetch faults: misaligned, above TEXT_HI, PC keeps advancing while faulting
    bus.redir_valid = 1'b1; bus.redir_pc = 32'h3002;
    tick();
    bus.redir_pc = 32'h7000;
    expect_f(32'h3002, 1'b0, 1'b0); observe();
    tick();
    bus.redir_valid = 1'b0;
    expect_f(32'h7000, 1'b0, 1'b0); observe();
    tick(); expect_f(32'h7004, 1'b0, 1'b0); observe();

    bus.redir_valid = 1'b1; bus.redir_pc = 32'h6FFC;
    tick();
    bus.redir_pc = 32'h2FFC;
    expect_f(32'h6FFC, 1'b0, 1'b0); observe();
    tick();
    bus.redir_pc = 32'hFFFF_FFFC;
    expect_f(32'h2FFC, 1'b0, 1'b0); observe();
    tick();
    bus.redir_valid = 1'b0;
    expect_f(32'hFFFF_FFFC, 1'b0, 1'b0); observe();
    tick();
    bus.exc_req = 1'b1;
    expect_f(32'h0000_0000, 1'b0, 1'b1); observe();
    tick();
    bus.exc_req = 1'b0;
    expect_f(32'h4180, 1'b0, 1'b0); observe();

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
